mc_datapath: RTL and testbench

- Parametrised multi-cycle successor to the current single-cycle datapath.
- Integrates its own control FSM, so no external CTRL_* inputs: fetch, execute, optional memory phase.
- Adds a variable-latency req/ack data-memory handshake, so the block works with slow or shared memories.
- Instruction ROM and data memory sit outside the block; the block drives their addresses.

---
 rtl/mc_defs_pkg.sv | 39 +++
 rtl/mc_alu.sv | 59 +++++
 rtl/mc_datapath.sv | 178 +++++++++++++++++
 tb/tb_mc_datapath.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_defs_pkg.sv
// Shared opcode/state encodings and instruction-field positions for the multi-cycle datapath.
// Field positions that depend on RAW are derived with ra_lsb().
package mc_defs_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHIFT = 4'd5,
    OP_ADDI  = 4'd6,
    OP_LW    = 4'd7,
    OP_SW    = 4'd8,
    OP_BZ    = 4'd9,
    OP_BNZ   = 4'd10,
    OP_JMP   = 4'd11,
    OP_MOV   = 4'd12,
    OP_NOP13 = 4'd13,
    OP_NOP14 = 4'd14,
    OP_HALT  = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int OP_W      = 4;
  localparam int FUNCT_BIT = 0;
  localparam int RB_LSB    = 1;

  function automatic int ra_lsb(input int raw);
    return RB_LSB + raw;
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for opcodes 0-6; zero latency, no handshake.
// Logic ops clear carry; SHIFT rotates one bit through carry.
module mc_alu
  import mc_defs_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    op,
  input  logic          funct,
  input  logic          c_in,
  output logic [DW-1:0] y,
  output logic          c_out,
  output logic          z
);

  logic [DW:0] sum;

  always_comb begin
    sum   = '0;
    y     = '0;
    c_out = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b} + (DW+1)'(funct & c_in);
        y     = sum[DW-1:0];
        c_out = sum[DW];
      end
      // Carry out of a + ~b + 1 is the no-borrow flag; SBC feeds C in place of the 1.
      OP_SUB: begin
        sum   = {1'b0, a} + {1'b0, ~b} + (DW+1)'(funct ? c_in : 1'b1);
        y     = sum[DW-1:0];
        c_out = sum[DW];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHIFT: begin
        if (funct) begin
          y     = {c_in, a[DW-1:1]};
          c_out = a[0];
        end else begin
          y     = {a[DW-2:0], c_in};
          c_out = a[DW-1];
        end
      end
      OP_ADDI: begin
        sum   = {1'b0, a} + {1'b0, b};
        y     = sum[DW-1:0];
        c_out = sum[DW];
      end
      default: ;
    endcase
  end

  assign z = (y == '0);

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: FETCH/EXEC(/MEM) FSM, CPI 2 for ALU/branch, 3 + wait for memory; stalls in MEM until dmem_ack.
// MC_DATAPATH_PERF_EN adds saturating cyc_cnt/ret_cnt outputs.
module mc_datapath
  import mc_defs_pkg::*;
#(
  parameter  int DW         = 8,
  parameter  int RAW        = 2,
  parameter  int PCW        = 16,
  parameter  int ABS_STRIDE = 4,
  localparam int IW         = 5 + 2*RAW
) (
  input  logic           CLK,
  input  logic           START,
  output logic [PCW-1:0] instr_addr,
  input  logic [IW-1:0]  instr_data,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_ack,
  output logic           DONE,
`ifdef MC_DATAPATH_PERF_EN
  output logic [31:0]    cyc_cnt,
  output logic [31:0]    ret_cnt,
`endif
  output logic [3:0]     opcode
);

  localparam int NREG   = 2**RAW;
  localparam int RA_LSB = ra_lsb(RAW);
  localparam int IMMB_W = 2*RAW + 1;
  localparam int IMMI_W = RAW + 1;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            z_q, z_d, c_q, c_d;
  logic [DW-1:0]   rf_q [NREG];
  logic            rf_we;
  logic [DW-1:0]   rf_wd;

  op_t             op;
  logic [RAW-1:0]  ra, rb;
  logic            funct;
  logic [IMMB_W-1:0] imm_b;
  logic [IMMI_W-1:0] imm_i;
  logic [DW-1:0]   alu_b, alu_y;
  logic            alu_c, alu_z;
  logic [PCW-1:0]  pc_inc, br_tgt, jmp_tgt;

  assign op    = op_t'(ir_q[IW-1 -: OP_W]);
  assign ra    = ir_q[RA_LSB +: RAW];
  assign rb    = ir_q[RB_LSB +: RAW];
  assign funct = ir_q[FUNCT_BIT];
  assign imm_b = ir_q[IMMB_W-1:0];
  assign imm_i = ir_q[IMMI_W-1:0];

  assign alu_b   = (op == OP_ADDI) ? DW'(imm_i) : rf_q[rb];
  assign pc_inc  = pc_q + PCW'(1);
  // Size cast of the signed immediate sign-extends (or truncates) to PCW before the modular add.
  assign br_tgt  = pc_q + PCW'($signed(imm_b));
  assign jmp_tgt = PCW'(32'(imm_b) * ABS_STRIDE);

  mc_alu #(.DW(DW)) u_alu (
    .a     (rf_q[ra]),
    .b     (alu_b),
    .op    (ir_q[IW-1 -: OP_W]),
    .funct (funct),
    .c_in  (c_q),
    .y     (alu_y),
    .c_out (alu_c),
    .z     (alu_z)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    c_d     = c_q;
    rf_we   = 1'b0;
    rf_wd   = alu_y;
    case (state_q)
      ST_FETCH: begin
        ir_d    = instr_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHIFT, OP_ADDI: begin
            rf_we = 1'b1;
            z_d   = alu_z;
            c_d   = alu_c;
          end
          OP_LW, OP_SW: begin
            state_d = ST_MEM;
            pc_d    = pc_q;
          end
          OP_BZ:   if (z_q)  pc_d = br_tgt;
          OP_BNZ:  if (!z_q) pc_d = br_tgt;
          OP_JMP:  pc_d = jmp_tgt;
          OP_MOV: begin
            rf_we = 1'b1;
            rf_wd = rf_q[rb];
          end
          OP_HALT: begin
            state_d = ST_HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
          if (op == OP_LW) begin
            rf_we = 1'b1;
            rf_wd = dmem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (START) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
      if (rf_we) rf_q[ra] <= rf_wd;
    end
  end

  // Address and data come straight from the register file, which cannot change while in MEM.
  assign instr_addr = pc_q;
  assign dmem_req   = (state_q == ST_MEM);
  assign dmem_we    = dmem_req && (op == OP_SW);
  assign dmem_addr  = rf_q[rb];
  assign dmem_wdata = rf_q[ra];
  assign DONE       = (state_q == ST_HALT);
  assign opcode     = ir_q[IW-1 -: OP_W];

`ifdef MC_DATAPATH_PERF_EN
  logic [31:0] cyc_q, ret_q;
  logic        retire;

  assign retire = (((state_q == ST_EXEC) || (state_q == ST_MEM)) && (state_d == ST_FETCH))
               || ((state_q == ST_EXEC) && (state_d == ST_HALT));

  always_ff @(posedge CLK) begin
    if (START) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if ((state_q != ST_HALT) && !(&cyc_q)) cyc_q <= cyc_q + 32'd1;
      if (retire && !(&ret_q))                ret_q <= ret_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: an instruction-level model predicts the per-cycle port trace of each directed program.
module tb_mc_datapath;
  localparam int PCW = 16;

  logic           CLK = 1'b0;
  logic           START = 1'b1;
  logic [PCW-1:0] instr_addr;
  logic [8:0]     instr_data;
  logic           dmem_req, dmem_we;
  logic [7:0]     dmem_addr, dmem_wdata;
  logic [7:0]     dmem_rdata = 8'h00;
  logic           dmem_ack = 1'b0;
  logic           DONE;
  logic [3:0]     opcode;
`ifdef MC_DATAPATH_PERF_EN
  logic [31:0]    cyc_cnt, ret_cnt, cyc_cnt4, ret_cnt4;
`endif

  logic           start4 = 1'b1;
  logic [3:0]     ia4;
  logic [8:0]     id4 = 9'h1A0;
  logic           req4, we4, done4;
  logic [7:0]     addr4, wdata4;
  logic [7:0]     rdata4 = 8'h00;
  logic           ack4 = 1'b0;
  logic [3:0]     opc4;

  logic [8:0] rom [256];
  logic [7:0] mem [256];

  always #5 CLK = ~CLK;
  assign instr_data = rom[instr_addr[7:0]];

  mc_datapath dut (
    .CLK(CLK), .START(START), .instr_addr(instr_addr), .instr_data(instr_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .DONE(DONE),
`ifdef MC_DATAPATH_PERF_EN
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
`endif
    .opcode(opcode)
  );

  mc_datapath #(.PCW(4)) dut4 (
    .CLK(CLK), .START(start4), .instr_addr(ia4), .instr_data(id4),
    .dmem_req(req4), .dmem_we(we4), .dmem_addr(addr4), .dmem_wdata(wdata4),
    .dmem_rdata(rdata4), .dmem_ack(ack4), .DONE(done4),
`ifdef MC_DATAPATH_PERF_EN
    .cyc_cnt(cyc_cnt4), .ret_cnt(ret_cnt4),
`endif
    .opcode(opc4)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  function automatic logic [8:0] enc(input int op, input int ra, input int rb, input int f);
    return {4'(op), 2'(ra), 2'(rb), 1'(f)};
  endfunction
  function automatic logic [8:0] enci(input int op, input int imm5);
    return {4'(op), 5'(imm5)};
  endfunction

  // Memory responder: acks after the next queued number of wait cycles.
  int wait_q[$];
  int mw_q[$];
  bit resp_en = 1'b0;
  int waited = 0;
  initial forever begin
    @(negedge CLK);
    if (resp_en) begin
      if (!dmem_req) begin
        dmem_ack = 1'b0;
        waited   = 0;
      end else if (waited >= ((wait_q.size() > 0) ? wait_q[0] : 0)) begin
        dmem_ack   = 1'b1;
        dmem_rdata = mem[dmem_addr];
        if (dmem_we) mem[dmem_addr] = dmem_wdata;
        if (wait_q.size() > 0) void'(wait_q.pop_front());
        waited = 0;
      end else begin
        dmem_ack = 1'b0;
        waited++;
      end
    end
  end

  typedef struct {
    int pc; int opc; bit req; bit we; int addr; int wdata; bit done;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input int pc, input int opc, input bit req, input bit we,
                      input int a, input int w, input bit done);
    exp_t e;
    e.pc = pc; e.opc = opc; e.req = req; e.we = we; e.addr = a; e.wdata = w; e.done = done;
    exp_q.push_back(e);
  endtask

  // Instruction-level model: executes the program and emits the cycle trace (2 cycles per
  // non-memory instruction, 3 + wait per memory access, DONE cycles after HALT).
  task automatic build_trace();
    int r[4];
    int m[256];
    int pc, z, c, prev, steps, npc;
    int ir, op, ra, rb, f, ib, ii, a, b, s, y, nc, w;
    bit halted;
    exp_q.delete();
    for (int i = 0; i < 4; i++) r[i] = 0;
    for (int i = 0; i < 256; i++) m[i] = mem[i];
    pc = 0; z = 0; c = 0; prev = 0; steps = 0; halted = 0;
    while (!halted && steps < 200) begin
      ir = rom[pc % 256];
      op = ir >> 5; ra = (ir >> 3) & 3; rb = (ir >> 1) & 3; f = ir & 1;
      ib = ir & 31; ii = ir & 7;
      a = r[ra]; b = r[rb]; y = 0;
      push(pc, prev, 0, 0, 0, 0, 0);
      push(pc, op, 0, 0, 0, 0, 0);
      npc = (pc + 1) % 65536;
      case (op)
        0: begin s = a + b + (f ? c : 0); c = (s > 255); y = s % 256; end
        1: begin s = a - b - (f ? (1 - c) : 0); c = (s >= 0); y = (s + 512) % 256; end
        2: begin y = a & b; c = 0; end
        3: begin y = a | b; c = 0; end
        4: begin y = a ^ b; c = 0; end
        5: begin
          if (f) begin nc = a % 2; y = a / 2 + 128 * c; end
          else   begin nc = a / 128; y = (a * 2 + c) % 256; end
          c = nc;
        end
        6: begin s = a + ii; c = (s > 255); y = s % 256; end
        7, 8: begin
          w = (mw_q.size() > 0) ? mw_q.pop_front() : 0;
          for (int k = 0; k <= w; k++) push(pc, op, 1, op == 8, b, a, 0);
          if (op == 7) r[ra] = m[b]; else m[b] = a;
        end
        9:  if (z)  npc = (pc + ((ib >= 16) ? ib - 32 : ib) + 65536) % 65536;
        10: if (!z) npc = (pc + ((ib >= 16) ? ib - 32 : ib) + 65536) % 65536;
        11: npc = ib * 4;
        12: r[ra] = b;
        15: begin
          halted = 1;
          npc = pc;
          for (int k = 0; k < 3; k++) push(pc, 15, 0, 0, 0, 0, 1);
        end
        default: ;
      endcase
      if (op <= 6) begin r[ra] = y; z = (y == 0); end
      prev = op; pc = npc; steps++;
    end
  endtask

  int obs_w[$];
  int req_runs[$];
  int pcs[$];
  int done_idx;

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic run_prog(input string tag);
    bit prev_req;
    int run;
    build_trace();
    obs_w.delete(); req_runs.delete(); pcs.delete();
    done_idx = -1; prev_req = 0; run = 0;
    resp_en = 1'b1;
    @(negedge CLK) START = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    cmp({tag, "_rst_pc"},  instr_addr, 0);
    cmp({tag, "_rst_req"}, dmem_req,   0);
    cmp({tag, "_rst_we"},  dmem_we,    0);
    cmp({tag, "_rst_done"}, DONE,      0);
    cmp({tag, "_rst_opc"}, opcode,     0);
    START = 1'b0;
    foreach (exp_q[k]) begin
      if (k > 0) begin
        @(negedge CLK);
        #1;
      end
      cmp($sformatf("%s_c%0d_pc", tag, k),   instr_addr, exp_q[k].pc);
      cmp($sformatf("%s_c%0d_opc", tag, k),  opcode,     exp_q[k].opc);
      cmp($sformatf("%s_c%0d_req", tag, k),  dmem_req,   exp_q[k].req);
      cmp($sformatf("%s_c%0d_done", tag, k), DONE,       exp_q[k].done);
      if (exp_q[k].req) begin
        cmp($sformatf("%s_c%0d_we", tag, k),   dmem_we,   exp_q[k].we);
        cmp($sformatf("%s_c%0d_addr", tag, k), dmem_addr, exp_q[k].addr);
        if (exp_q[k].we) cmp($sformatf("%s_c%0d_wdata", tag, k), dmem_wdata, exp_q[k].wdata);
      end
      if (pcs.size() == 0 || pcs[$] != int'(instr_addr)) pcs.push_back(int'(instr_addr));
      if (dmem_req) begin
        run++;
        if (!prev_req && dmem_we) obs_w.push_back(int'(dmem_wdata));
      end else if (prev_req) begin
        req_runs.push_back(run);
        run = 0;
      end
      prev_req = dmem_req;
      if (DONE && done_idx < 0) done_idx = k;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      rom[i] = enci(15, 0);
      mem[i] = 8'(i * 3 + 1);
    end
    wait_q.delete(); mw_q.delete();
  endtask

  initial begin
    int seen15, nxt, found, wd;
    int exp_a[8];
    int exp_b[6];

    // PC wrap on the PCW=4 instance: all NOPs, 15 must be followed by 0.
    @(negedge CLK);
    @(negedge CLK) start4 = 1'b0;
    seen15 = 0; nxt = -1;
    for (int i = 0; i < 60 && nxt < 0; i++) begin
      @(negedge CLK);
      #1;
      if (seen15 != 0 && ia4 != 4'd15) nxt = int'(ia4);
      if (ia4 == 4'd15) seen15 = 1;
    end
    cmp("wrap_seen15", seen15, 1);
    cmp("wrap_next_pc", nxt, 0);
    cmp("wrap_done", done4, 0);
    cmp("wrap_req", req4, 0);
    cmp("wrap_opc", opc4, 13);

    // Reset/fetch: ADDI r1,#5 ; HALT
    clear_prog();
    rom[0] = enc(6, 1, 2, 1);
    rom[1] = enci(15, 0);
    run_prog("fetch");
    cmp("fetch_done_cycle", done_idx, 4);
    cmp("fetch_halt_pc", instr_addr, 1);
    cmp("fetch_halt_done", DONE, 1);

    // ADD/ADC carry chain, stored back through SW.
    clear_prog();
    rom[0] = enc(6, 2, 0, 1);
    rom[1] = enc(1, 1, 2, 0);
    rom[2] = enc(0, 1, 2, 0);
    rom[3] = enc(0, 3, 3, 1);
    rom[4] = enc(8, 1, 0, 0);
    rom[5] = enc(8, 3, 0, 0);
    rom[6] = enc(0, 0, 0, 1);
    rom[7] = enc(8, 0, 0, 0);
    rom[8] = enci(15, 0);
    wait_q = {0, 1, 0}; mw_q = wait_q;
    run_prog("adc");
    cmp("adc_nstores", obs_w.size(), 3);
    cmp("adc_r1", qget(obs_w, 0), 8'h00);
    cmp("adc_r3", qget(obs_w, 1), 8'h01);
    cmp("adc_c_cleared", qget(obs_w, 2), 8'h00);

    // Logic ops, shifts, SBC, MOV.
    clear_prog();
    rom[0]  = enc(6, 1, 3, 0);
    rom[1]  = enc(6, 2, 1, 1);
    rom[2]  = enc(4, 1, 2, 0);
    rom[3]  = enc(2, 2, 1, 0);
    rom[4]  = enc(3, 2, 1, 0);
    rom[5]  = enc(5, 1, 0, 0);
    rom[6]  = enc(1, 2, 1, 0);
    rom[7]  = enc(1, 1, 2, 1);
    rom[8]  = enc(5, 2, 0, 1);
    rom[9]  = enc(12, 3, 2, 0);
    rom[10] = enc(8, 1, 0, 0);
    rom[11] = enc(8, 3, 0, 0);
    rom[12] = enci(15, 0);
    run_prog("alu");
    cmp("alu_sbc", qget(obs_w, 0), 8'h0E);
    cmp("alu_shr_mov", qget(obs_w, 1), 8'h7D);

    // Memory wait: LW with 3 wait cycles, then a same-cycle-ack SW.
    clear_prog();
    mem[4] = 8'hA5;
    rom[0] = enc(6, 2, 2, 0);
    rom[1] = enc(7, 0, 2, 0);
    rom[2] = enc(8, 0, 1, 0);
    rom[3] = enci(15, 0);
    wait_q = {3, 0}; mw_q = wait_q;
    run_prog("mem");
    cmp("mem_lw_req_cycles", qget(req_runs, 0), 4);
    cmp("mem_sw_req_cycles", qget(req_runs, 1), 1);
    cmp("mem_lw_data", qget(obs_w, 0), 8'hA5);

    // Branches: BZ taken (10 -> 8), BZ not taken, JMP #3 -> 12.
    clear_prog();
    rom[0]  = enc(1, 0, 0, 0);
    rom[1]  = enci(11, 3);
    rom[12] = enci(9, -2);
    rom[10] = enci(9, -2);
    rom[8]  = enc(6, 1, 0, 1);
    rom[9]  = enci(13, 0);
    rom[11] = enci(15, 0);
    run_prog("bra");
    exp_a = '{0, 1, 12, 10, 8, 9, 10, 11};
    cmp("bra_npcs", pcs.size(), 8);
    foreach (exp_a[i]) cmp($sformatf("bra_pc%0d", i), qget(pcs, i), exp_a[i]);

    // BNZ with Z=1 at PC=10 falls through to 11.
    clear_prog();
    rom[0]  = enc(1, 0, 0, 0);
    rom[1]  = enci(11, 2);
    rom[8]  = enci(13, 0);
    rom[9]  = enci(14, 0);
    rom[10] = enci(10, -2);
    rom[11] = enci(15, 0);
    run_prog("brb");
    exp_b = '{0, 1, 8, 9, 10, 11};
    cmp("brb_npcs", pcs.size(), 6);
    foreach (exp_b[i]) cmp($sformatf("brb_pc%0d", i), qget(pcs, i), exp_b[i]);

    // Reset while a load is pending, with the ack landing in the reset cycle.
    clear_prog();
    mem[4] = 8'hA5;
    rom[0] = enc(6, 2, 2, 0);
    rom[1] = enc(7, 0, 2, 0);
    resp_en = 1'b0;
    dmem_ack = 1'b0;
    @(negedge CLK) START = 1'b1;
    @(negedge CLK);
    @(negedge CLK) START = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge CLK);
      #1;
      if (dmem_req) found = 1;
    end
    cmp("midmem_req_seen", found, 1);
    START = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 8'hA5;
    rom[0] = enc(8, 0, 1, 0);
    rom[1] = enci(15, 0);
    @(negedge CLK);
    #1;
    cmp("midmem_req_after", dmem_req, 0);
    cmp("midmem_pc_after", instr_addr, 0);
    dmem_ack = 1'b0;
    START = 1'b0;
    resp_en = 1'b1;
    wd = -1;
    for (int i = 0; i < 20 && wd < 0; i++) begin
      @(negedge CLK);
      #1;
      if (dmem_req && dmem_we) wd = int'(dmem_wdata);
    end
    cmp("midmem_r0_unchanged", wd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
